hex_seg7_scan6: RTL and testbench

- Time-multiplexed driver for a 6-digit, common-anode 7-segment display.
- Takes six 8-bit digit values from the memory-mapped display region of the data memory.
- Decodes the low nibble of each value to a hex glyph and scans one digit at a time.
- Drives active-low segment lines and active-low digit-select lines.

---
 rtl/hex_seg7_pkg.sv | 25 ++
 rtl/hex_to_seg7.sv | 30 +++
 rtl/hex_seg7_scan6.sv | 84 ++++++++
 tb/tb_hex_seg7_scan6.sv | 133 +++++++++++++
 4 files changed

// File: rtl/hex_seg7_pkg.sv
// hex_seg7_pkg
// Shared constants for the 6-digit hex 7-segment scanner.
//   NUM_DIGITS : number of scanned digits (fixed)
//   SEG_OFF    : all segments dark (active-low)
//   SEL_OFF    : all digit selects inactive (active-low)
//   GLYPH      : hex nibble -> seg[6:0] (a..g), 0 = lit
package hex_seg7_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [5:0] sel_t;

   localparam int unsigned NUM_DIGITS = 6;
   localparam seg_t        SEG_OFF    = 7'h7F;
   localparam sel_t        SEL_OFF    = 6'h3F;

   localparam seg_t GLYPH [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
   };

   function automatic seg_t glyph(input logic [3:0] hex);
      return GLYPH[hex];
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
// Combinational hex-nibble to common-anode 7-segment glyph decoder.
// Ports:
//   hex   in  4  nibble to decode
//   blank in  1  force all segments dark (honoured only with SEG7_BLANK_EN)
//   seg   out 7  active-low segments, seg[6]=a .. seg[0]=g
// Build option: `define SEG7_BLANK_EN to enable blanking.
module hex_to_seg7
   import hex_seg7_pkg::*;
(
   input  logic [3:0] hex,
   input  logic       blank,
   output logic [6:0] seg
);

`ifdef SEG7_BLANK_EN
   always_comb begin
      seg = glyph(hex);
      if (blank) seg = SEG_OFF;
   end
`else
   logic w_unused_blank;
   assign w_unused_blank = blank;

   always_comb begin
      seg = glyph(hex);
   end
`endif

endmodule

// File: rtl/hex_seg7_scan6.sv
// hex_seg7_scan6
// Time-multiplexed driver for a 6-digit common-anode 7-segment display.
// Each digit is lit for SCAN_DIV clocks; outputs are registered and lag
// the digit index by one cycle.
// Ports:
//   CLK    in  1  system clock, rising edge
//   RESET  in  1  synchronous active-low reset
//   d0..d5 in  8  digit values (low nibble decoded; bit 7 blanks with
//                 SEG7_BLANK_EN)
//   seg    out 7  active-low segments, seg[6]=a .. seg[0]=g
//   sel    out 6  active-low digit selects, sel[0]=DIG1 .. sel[5]=DIG6
// Build option: `define SEG7_BLANK_EN to enable per-digit blanking.
module hex_seg7_scan6 #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] d0,
   input  logic [7:0] d1,
   input  logic [7:0] d2,
   input  logic [7:0] d3,
   input  logic [7:0] d4,
   input  logic [7:0] d5,
   output logic [6:0] seg,
   output logic [5:0] sel
);
   import hex_seg7_pkg::*;

   localparam int unsigned     CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [6:0]       r_seg;
   logic [5:0]       r_sel;

   logic [7:0]       w_dig;
   logic [6:0]       w_seg;
   logic             w_unused_hi;

   always_comb begin
      w_dig = d0;
      case (r_idx)
         3'd1:    w_dig = d1;
         3'd2:    w_dig = d2;
         3'd3:    w_dig = d3;
         3'd4:    w_dig = d4;
         3'd5:    w_dig = d5;
         default: w_dig = d0;
      endcase
   end

   assign w_unused_hi = ^w_dig[6:4];

   hex_to_seg7 u_dec (
      .hex   (w_dig[3:0]),
      .blank (w_dig[7]),
      .seg   (w_seg)
   );

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_cnt <= '0;
         r_idx <= '0;
         r_sel <= SEL_OFF;
         r_seg <= SEG_OFF;
      end else begin
         if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         // Outputs use the pre-update index, so they trail r_idx by one edge.
         r_sel <= ~(6'b000001 << r_idx);
         r_seg <= w_seg;
      end
   end

   assign seg = r_seg;
   assign sel = r_sel;

endmodule

// File: tb/tb_hex_seg7_scan6.sv
module tb_hex_seg7_scan6;

   localparam int unsigned SD = 4;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [7:0] dv [6];
   logic [6:0] seg;
   logic [5:0] sel;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned n = 0;      // non-reset edges since the last reset edge

   // Reference glyph table, written straight from the display chart.
   logic [6:0] ref_glyph [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
   };

   always #5 CLK = ~CLK;

   hex_seg7_scan6 #(.SCAN_DIV(SD)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .d0    (dv[0]),
      .d1    (dv[1]),
      .d2    (dv[2]),
      .d3    (dv[3]),
      .d4    (dv[4]),
      .d5    (dv[5]),
      .seg   (seg),
      .sel   (sel)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
      end
   endtask

   // Predicts the outputs for the coming edge from elapsed time since reset:
   // edge k after release shows digit (k / SCAN_DIV) mod 6.
   task automatic tick();
      logic [6:0]  es;
      logic [5:0]  el;
      logic [7:0]  v;
      int unsigned dig;
      if (!RESET) begin
         es = 7'h7F;
         el = 6'h3F;
      end else begin
         dig = (n / SD) % 6;
         v   = dv[dig];
         el  = 6'h3F;
         el[dig] = 1'b0;
         es  = ref_glyph[v[3:0]];
`ifdef SEG7_BLANK_EN
         if (v[7]) es = 7'h7F;
`endif
      end
      @(posedge CLK);
      #1;
      chk("seg", {25'd0, seg}, {25'd0, es});
      chk("sel", {26'd0, sel}, {26'd0, el});
      if (!RESET) n = 0;
      else n++;
   endtask

   task automatic run(input int unsigned cycles);
      for (int unsigned i = 0; i < cycles; i++) tick();
   endtask

   task automatic advance_to(input int unsigned phase);
      for (int unsigned i = 0; i < 6 * SD && (n % (6 * SD)) != phase; i++) tick();
   endtask

   initial begin
      for (int i = 0; i < 6; i++) dv[i] = 8'($urandom);

      // Reset held for three edges with arbitrary inputs
      RESET = 1'b0;
      run(3);
      RESET = 1'b1;

      // Scan order with 0..5
      for (int i = 0; i < 6; i++) dv[i] = 8'(i);
      run(2 * 6 * SD + 2);

      // Glyph sweep on d0 with varied upper bits (bit 7 clear)
      for (int unsigned v = 0; v < 16; v++) begin
         dv[0] = {1'b0, 3'($urandom), 4'(v)};
         advance_to(0);
         run(SD);
      end
      dv[0] = 8'h3A;
      advance_to(0);
      run(SD);

      // Reset mid-scan at idx=3, cnt=2, then a full restart
      advance_to(3 * SD + 2);
      RESET = 1'b0;
      tick();
      RESET = 1'b1;
      run(2 * SD + 1);

      // Live update while DIG3 is shown
      dv[2] = 8'h07;
      advance_to(2 * SD + 1);
      dv[2] = 8'h08;
      run(SD);

      // Bit-7 digit: blank when the option is built in, else glyph 5
      dv[4] = 8'h85;
      advance_to(4 * SD);
      run(SD + 1);

      // Random inputs every cycle with occasional resets
      for (int unsigned i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) dv[$urandom_range(0, 5)] = 8'($urandom);
         RESET = ($urandom_range(0, 49) != 0);
         tick();
      end
      RESET = 1'b1;
      run(6 * SD);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
